// File: rtl/decoder_3to8_sweep.sv
// Switch-driven 3-to-8 one-hot decoder with a manual load strobe and an
// optional timed up/down sweep of the decoded code.
module decoder_3to8_sweep #(
  parameter int unsigned DIV = 50000000
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic SW0,
  input  logic SW1,
  input  logic SW2,
  input  logic SW3,
  input  logic SW4,
  input  logic BTN0,
  output logic LED0,
  output logic LED1,
  output logic LED2,
  output logic LED3,
  output logic LED4,
  output logic LED5,
  output logic LED6,
  output logic LED7
);

  localparam int unsigned CW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned NSYNC  = 6;
  localparam int unsigned CODE_W = 3;
  localparam int unsigned LED_W  = 8;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [NSYNC-1:0]  sync_meta;
  logic [NSYNC-1:0]  sync_q;
  logic              btn_prev;
  logic              mode_prev;
  logic [CODE_W-1:0] code_q;
  logic [CODE_W-1:0] code_d;
  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     cnt_d;
  logic [LED_W-1:0]  led_q;
  logic [LED_W-1:0]  led_d;

  logic [CODE_W-1:0] sw_c;
  logic              mode_c;
  logic              dir_c;
  logic              btn_c;
  logic              load_c;
  logic              mode_chg_c;
  logic              tick_c;

  // Two-flop synchronizers for every asynchronous input
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_meta <= '0;
      sync_q    <= '0;
    end else begin
      sync_meta <= {BTN0, SW4, SW3, SW2, SW1, SW0};
      sync_q    <= sync_meta;
    end
  end

  assign sw_c   = sync_q[2:0];
  assign mode_c = sync_q[3];
  assign dir_c  = sync_q[4];
  assign btn_c  = sync_q[5];

  // Edge-detect history resets to 0 so a button held through reset still loads once
  assign load_c     = btn_c & ~btn_prev;
  assign mode_chg_c = mode_c ^ mode_prev;
  assign tick_c     = mode_c & ~mode_chg_c & (cnt_q == LAST);

  always_comb begin
    cnt_d  = cnt_q;
    code_d = code_q;
    led_d  = LED_W'(1) << code_q;

    if (!mode_c || mode_chg_c || tick_c) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    // Load has priority over a coincident step; the step is simply dropped
    if (load_c) begin
      code_d = sw_c;
    end else if (tick_c) begin
      code_d = dir_c ? (code_q - CODE_W'(1)) : (code_q + CODE_W'(1));
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      btn_prev  <= 1'b0;
      mode_prev <= 1'b0;
      cnt_q     <= '0;
      code_q    <= '0;
      led_q     <= LED_W'(1);
    end else begin
      btn_prev  <= btn_c;
      mode_prev <= mode_c;
      cnt_q     <= cnt_d;
      code_q    <= code_d;
      led_q     <= led_d;
    end
  end

  assign LED0 = led_q[0];
  assign LED1 = led_q[1];
  assign LED2 = led_q[2];
  assign LED3 = led_q[3];
  assign LED4 = led_q[4];
  assign LED5 = led_q[5];
  assign LED6 = led_q[6];
  assign LED7 = led_q[7];

endmodule

// File: tb/tb_decoder_3to8_sweep.sv
// Directed bench for decoder_3to8_sweep with DIV=4; expected LED patterns are
// hand-derived per cycle counted in falling edges after each stimulus change.
module tb_decoder_3to8_sweep;

  logic CLK;
  logic RST_N;
  logic SW0, SW1, SW2, SW3, SW4, BTN0;
  logic LED0, LED1, LED2, LED3, LED4, LED5, LED6, LED7;
  logic [7:0] leds;

  int checks;
  int errors;

  decoder_3to8_sweep #(.DIV(4)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .SW0(SW0), .SW1(SW1), .SW2(SW2), .SW3(SW3), .SW4(SW4), .BTN0(BTN0),
    .LED0(LED0), .LED1(LED1), .LED2(LED2), .LED3(LED3),
    .LED4(LED4), .LED5(LED5), .LED6(LED6), .LED7(LED7)
  );

  assign leds = {LED7, LED6, LED5, LED4, LED3, LED2, LED1, LED0};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic set_sw(input logic [2:0] c);
    {SW2, SW1, SW0} = c;
  endtask

  // Manual-mode load helper: press long enough to load, then release and settle
  task automatic do_load(input logic [2:0] c);
    set_sw(c);
    BTN0 = 1'b1;
    cyc(4);
    BTN0 = 1'b0;
    cyc(4);
  endtask

  task automatic test_reset;
    logic [7:0] exp;
    RST_N = 1'b0;
    {SW4, SW3, SW2, SW1, SW0, BTN0} = '0;
    cyc(3);
    exp = 8'h01;
    checks++;
    if (leds !== exp) begin
      errors++;
      $display("FAIL reset_hold got %h exp %h", leds, exp);
    end
    RST_N = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge CLK);
      checks++;
      if (leds !== exp) begin
        errors++;
        $display("FAIL reset_idle k=%0d got %h exp %h", k, leds, exp);
      end
    end
  endtask

  task automatic test_manual_load;
    logic [7:0] exp;
    SW3 = 1'b0;
    set_sw(3'b101);
    cyc(3);
    BTN0 = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge CLK);
      exp = (k < 4) ? 8'h01 : 8'h20;
      checks++;
      if (leds !== exp) begin
        errors++;
        $display("FAIL manual_load k=%0d got %h exp %h", k, leds, exp);
      end
      if (k == 5) set_sw(3'b010);
      if (k == 10) BTN0 = 1'b0;
    end
  endtask

  task automatic test_sweep_up;
    logic [7:0] exp;
    do_load(3'b110);
    SW4 = 1'b0;
    SW3 = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      @(negedge CLK);
      if (k < 8)       exp = 8'h40;
      else if (k < 12) exp = 8'h80;
      else if (k < 16) exp = 8'h01;
      else             exp = 8'h02;
      checks++;
      if (leds !== exp) begin
        errors++;
        $display("FAIL sweep_up k=%0d got %h exp %h", k, leds, exp);
      end
      if (k == 16) SW3 = 1'b0;
    end
  endtask

  task automatic test_sweep_down;
    logic [7:0] exp;
    do_load(3'b001);
    SW4 = 1'b1;
    SW3 = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge CLK);
      if (k < 8)       exp = 8'h02;
      else if (k < 12) exp = 8'h01;
      else if (k < 16) exp = 8'h80;
      else             exp = 8'h40;
      checks++;
      if (leds !== exp) begin
        errors++;
        $display("FAIL sweep_down k=%0d got %h exp %h", k, leds, exp);
      end
    end
    SW3 = 1'b0;
    cyc(4);
    SW4 = 1'b0;
    cyc(2);
  endtask

  task automatic test_load_on_tick;
    logic [7:0] exp;
    do_load(3'b000);
    SW3 = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge CLK);
      if (k < 8)       exp = 8'h01;
      else if (k < 12) exp = 8'h02;
      else if (k < 16) exp = 8'h08;
      else             exp = 8'h10;
      checks++;
      if (leds !== exp) begin
        errors++;
        $display("FAIL load_on_tick k=%0d got %h exp %h", k, leds, exp);
      end
      if (k == 8) begin
        set_sw(3'b011);
        BTN0 = 1'b1;
      end
    end
    BTN0 = 1'b0;
    SW3 = 1'b0;
    cyc(4);
  endtask

  task automatic test_reset_mid_sweep;
    logic [7:0] exp;
    do_load(3'b100);
    SW3 = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge CLK);
      exp = (k < 8) ? 8'h10 : 8'h20;
      checks++;
      if (leds !== exp) begin
        errors++;
        $display("FAIL pre_reset k=%0d got %h exp %h", k, leds, exp);
      end
    end
    #1 RST_N = 1'b0;
    #1;
    exp = 8'h01;
    checks++;
    if (leds !== exp) begin
      errors++;
      $display("FAIL async_reset got %h exp %h", leds, exp);
    end
    cyc(2);
    RST_N = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge CLK);
      if (k < 8)       exp = 8'h01;
      else if (k < 12) exp = 8'h02;
      else             exp = 8'h04;
      checks++;
      if (leds !== exp) begin
        errors++;
        $display("FAIL restart_sweep k=%0d got %h exp %h", k, leds, exp);
      end
    end
    SW3 = 1'b0;
    cyc(4);
  endtask

  task automatic test_btn_at_reset;
    logic [7:0] exp;
    RST_N = 1'b0;
    SW3 = 1'b0;
    SW4 = 1'b0;
    set_sw(3'b110);
    BTN0 = 1'b1;
    cyc(2);
    RST_N = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge CLK);
      exp = (k < 4) ? 8'h01 : 8'h40;
      checks++;
      if (leds !== exp) begin
        errors++;
        $display("FAIL btn_at_reset k=%0d got %h exp %h", k, leds, exp);
      end
      if (k == 5) set_sw(3'b001);
    end
    BTN0 = 1'b0;
    cyc(2);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_manual_load();
    test_sweep_up();
    test_sweep_down();
    test_load_on_tick();
    test_reset_mid_sweep();
    test_btn_at_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
